// File: rtl/writeback_pkg.sv
// Shared types and constants for the LC3 writeback stage: result-select
// encoding, condition-code values and register/index types.
package writeback_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_PC   = 2'd1,
        WB_MEM  = 2'd2,
        WB_NONE = 2'd3
    } wctl_e;

    localparam logic [2:0] PSR_N = 3'b100;
    localparam logic [2:0] PSR_Z = 3'b010;
    localparam logic [2:0] PSR_P = 3'b001;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [IDX_W-1:0]  reg_idx_t;

endpackage

// File: rtl/lc3_regfile.sv
// LC3 architectural register file: NREG x DW storage, one synchronous write
// port, two combinational read ports, asynchronous active-high reset.
module lc3_regfile
    import writeback_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem [NREG];

    // Storage: cleared on reset, written only on an enabled edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: selects the committed result, writes the register
// file, updates the {N,Z,P} condition codes and drives operand read-out.
// Optional macro LC3_WB_BYPASS_EN adds a same-cycle write-to-read bypass.
module lc3_writeback
    import writeback_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable_writeback,
    input  logic [1:0]    W_Control,
    input  logic [DW-1:0] aluout,
    input  logic [DW-1:0] pcout,
    input  logic [DW-1:0] memout,
    input  logic [AW-1:0] dr,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    output logic [DW-1:0] vsr1,
    output logic [DW-1:0] vsr2,
    output logic [2:0]    psr,
    output logic          enable_writeback_out
);

    logic [DW-1:0] sel;
    logic          wr_en;
    logic [2:0]    psr_next;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    // Result select; the reserved encoding produces no commit.
    always_comb begin
        sel = '0;
        case (W_Control)
            WB_ALU:  sel = aluout;
            WB_PC:   sel = pcout;
            WB_MEM:  sel = memout;
            default: sel = '0;
        endcase
    end

    // Reset gates the commit so a bypassed value never leaks out during reset.
    assign wr_en = enable_writeback && (W_Control != WB_NONE) && !reset;

    always_comb begin
        psr_next = PSR_P;
        if (sel[DW-1]) begin
            psr_next = PSR_N;
        end else if (sel == '0) begin
            psr_next = PSR_Z;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            psr                  <= 3'b000;
            enable_writeback_out <= 1'b0;
        end else begin
            enable_writeback_out <= enable_writeback;
            if (wr_en) begin
                psr <= psr_next;
            end
        end
    end

    lc3_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (wr_en),
        .waddr  (dr),
        .wdata  (sel),
        .raddr1 (sr1),
        .raddr2 (sr2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

`ifdef LC3_WB_BYPASS_EN
    // Forward the in-flight commit to a port reading the destination register.
    always_comb begin
        vsr1 = rd1;
        vsr2 = rd2;
        if (wr_en && (sr1 == dr)) begin
            vsr1 = sel;
        end
        if (wr_en && (sr2 == dr)) begin
            vsr2 = sel;
        end
    end
`else
    assign vsr1 = rd1;
    assign vsr2 = rd2;
`endif

endmodule
